// File: rtl/core_req_injector_pkg.sv
// Shared constants for the per-core request injector: default network widths,
// FSM state encodings and small helpers for priority and backoff length.
package core_req_injector_pkg;

   localparam int N_CORES   = 4;
   localparam int ADDR_BITS = 8;
   localparam int DATA_BITS = 16;

   typedef logic [2:0] inj_state_t;

   localparam inj_state_t INJ_IDLE    = 3'd0;
   localparam inj_state_t INJ_INJECT  = 3'd1;
   localparam inj_state_t INJ_WAIT    = 3'd2;
   localparam inj_state_t INJ_BACKOFF = 3'd3;
   localparam inj_state_t INJ_DONE    = 3'd4;

   // Priority climbs by one per retry and sticks at the top level.
   function automatic logic [1:0] pri_bump(input logic [1:0] p);
      return (p == 2'b11) ? 2'b11 : p + 2'd1;
   endfunction

   // Backoff length (2^rc)-1 with rc capped at 4.
   function automatic logic [3:0] backoff_len(input logic [3:0] rc);
      logic [3:0] len;
      case (rc)
         4'd0:    len = 4'd0;
         4'd1:    len = 4'd1;
         4'd2:    len = 4'd3;
         4'd3:    len = 4'd7;
         default: len = 4'd15;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/inj_backoff_timer.sv
// Backoff down-counter for the request injector; only built when
// INJECTOR_BACKOFF_EN is defined.
`ifdef INJECTOR_BACKOFF_EN
module inj_backoff_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       count,
   output logic       expire
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // A load of L keeps the counting state alive for exactly L cycles.
   assign expire = count && (cnt <= 4'd1);

endmodule
`endif

// File: rtl/core_req_injector.sv
// Per-core request injector feeding a stage-0 switch input; retries dropped or
// timed-out packets with rising priority. INJECTOR_BACKOFF_EN adds retry backoff.
module core_req_injector
   import core_req_injector_pkg::*;
#(
   parameter int CORE_ID   = 0,
   parameter int N         = N_CORES,
   parameter int ADDR_W    = ADDR_BITS,
   parameter int DATA_W    = DATA_BITS,
   parameter int TIMEOUT   = 64,
   parameter int MAX_RETRY = 7,
   localparam int CORE_ID_BITS  = (N > 1) ? $clog2(N) : 1,
   localparam int PACKET_W      = CORE_ID_BITS + 3 + ADDR_W + DATA_W,
   localparam int BACK_PACKET_W = CORE_ID_BITS + DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic [PACKET_W-1:0]      pkt_out,
   output logic                     pkt_valid,
   input  logic [N-1:0]             drop_vec,
   input  logic [BACK_PACKET_W-1:0] bresp_pkt,
   input  logic                     bresp_vld,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [3:0]               retry_cnt
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CORE_ID_BITS-1:0] MY_ID       = CORE_ID_BITS'(CORE_ID);
   localparam logic [TW-1:0]           TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [3:0]              RETRY_LIMIT = 4'(MAX_RETRY);
   localparam logic [N-1:0]            OWN_BIT     = N'(1) << CORE_ID;

   inj_state_t          state;
   inj_state_t          state_nxt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [1:0]          pri_q;
   logic [3:0]          retry_q;
   logic [TW-1:0]       timer_q;
   logic                err_q;

   logic                match;
   logic                own_drop;
   logic                timed_out;
   logic                retry_evt;
   logic                give_up;

   assign match     = bresp_vld && (bresp_pkt[BACK_PACKET_W-1 -: CORE_ID_BITS] == MY_ID);
   assign own_drop  = |(drop_vec & OWN_BIT);
   assign timed_out = (timer_q == TIMER_LAST);
   assign retry_evt = own_drop || timed_out;
   assign give_up   = (retry_q == RETRY_LIMIT);

`ifdef INJECTOR_BACKOFF_EN
   logic backoff_load;
   logic backoff_done;

   assign backoff_load = (state == INJ_WAIT) && !match && retry_evt && !give_up;

   inj_backoff_timer u_backoff (
      .clk      (clk),
      .rst      (rst),
      .load     (backoff_load),
      .load_val (backoff_len(retry_q + 4'd1)),
      .count    (state == INJ_BACKOFF),
      .expire   (backoff_done)
   );
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         INJ_IDLE:   if (req_valid) state_nxt = INJ_INJECT;
         INJ_INJECT: state_nxt = INJ_WAIT;
         INJ_WAIT: begin
            // A matching response beats a same-cycle drop or timeout.
            if (match) begin
               state_nxt = INJ_DONE;
            end else if (retry_evt) begin
`ifdef INJECTOR_BACKOFF_EN
               state_nxt = give_up ? INJ_DONE : INJ_BACKOFF;
`else
               state_nxt = give_up ? INJ_DONE : INJ_INJECT;
`endif
            end
         end
`ifdef INJECTOR_BACKOFF_EN
         INJ_BACKOFF: if (backoff_done) state_nxt = INJ_INJECT;
`else
         INJ_BACKOFF: state_nxt = INJ_INJECT;
`endif
         INJ_DONE:   state_nxt = INJ_IDLE;
         default:    state_nxt = INJ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INJ_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         pri_q   <= 2'd0;
         retry_q <= 4'd0;
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            INJ_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  pri_q   <= 2'd0;
                  retry_q <= 4'd0;
                  err_q   <= 1'b0;
               end
            end
            INJ_INJECT: timer_q <= '0;
            INJ_WAIT: begin
               if (match) begin
                  rdata_q <= we_q ? '0 : bresp_pkt[DATA_W-1:0];
               end else if (retry_evt) begin
                  if (give_up) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     retry_q <= retry_q + 4'd1;
                     pri_q   <= pri_bump(pri_q);
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake: a request transfers on a cycle with req_valid && req_ready;
   // req_ready is high only in IDLE, and the request fields are latched then.
   assign req_ready = (state == INJ_IDLE);
   assign pkt_valid = (state == INJ_INJECT);
   assign pkt_out   = pkt_valid ? {MY_ID, pri_q, we_q, addr_q, wdata_q} : '0;
   assign rsp_valid = (state == INJ_DONE);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid && err_q;
   assign retry_cnt = retry_q;

endmodule
